// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Step counter width: ceil(log2(n)), never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fulladd.sv
// One-bit full-adder cell; chained to form a ripple digit.
// Latency: combinational.
// Backpressure: none.
module fulladd (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic Q,
  output logic COUT
);

  assign Q    = A ^ B ^ CIN;
  assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per clock, LSB first.
// Latency: DONE in the cycle after edge e0+N (N = WIDTH/DIGIT); one result per N+1 cycles.
// Backpressure: START is only taken while READY=1; START during RUN is ignored.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic             COUT,
  output logic             OVF
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must be >=1 and divide WIDTH (>=1)");
  end

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  // r_opa doubles as the result accumulator: sum digits shift in at the top
  // while operand digits shift out at the bottom.
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic             r_sub;
  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_sum;
  logic [WIDTH-1:0] w_opa_next;
  logic [WIDTH-1:0] w_opb_next;

  // Ripple chain of DIGIT cells over the low digit of the shifting operands.
  assign w_c[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    fulladd u_fa (
      .A   (r_opa[i]),
      .B   (r_opb[i]),
      .CIN (w_c[i]),
      .Q   (w_sum[i]),
      .COUT(w_c[i+1])
    );
  end

  // Single-digit case has nothing left to shift after the only step.
  if (DIGIT == WIDTH) begin : g_one_digit
    assign w_opa_next = w_sum;
    assign w_opb_next = '0;
  end else begin : g_multi_digit
    assign w_opa_next = {w_sum, r_opa[WIDTH-1:DIGIT]};
    assign w_opb_next = {{DIGIT{1'b0}}, r_opb[WIDTH-1:DIGIT]};
  end

  // Control FSM plus operand/carry datapath and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_q     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (START) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_opa   <= A;
            r_opb   <= SUB ? ~B : B;
            r_carry <= SUB ? ~CIN : CIN;
            r_sub   <= SUB;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_opa   <= w_opa_next;
          r_opb   <= w_opb_next;
          r_carry <= w_c[DIGIT];
          if (r_cnt == LAST) begin
            r_state <= FIN;
            r_q     <= w_opa_next;
            // Subtraction ran as A + ~B + ~CIN, so carry-out is the inverted borrow.
            r_cout  <= r_sub ^ w_c[DIGIT];
            r_ovf   <= w_c[DIGIT-1] ^ w_c[DIGIT];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign READY = (r_state != RUN);
  assign DONE  = (r_state == FIN);
  assign Q     = r_q;
  assign COUT  = r_cout;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder in three configurations (8/1, 8/4, 1/1).
// Latency: checks DONE timing against N+1 cycles from the START cycle.
// Backpressure: exercises START during RUN (ignored) and during FIN (accepted).
module tb_serial_adder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] q;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int done_a = 0;
  int done_b = 0;
  int done_c = 0;

  // DUT a: WIDTH=8, DIGIT=1
  logic       a_rst_n, a_start, a_sub, a_cin, a_ready, a_done, a_cout, a_ovf;
  logic [7:0] a_a, a_b, a_q;
  // DUT b: WIDTH=8, DIGIT=4
  logic       b_rst_n, b_start, b_sub, b_cin, b_ready, b_done, b_cout, b_ovf;
  logic [7:0] b_a, b_b, b_q;
  // DUT c: WIDTH=1, DIGIT=1
  logic       c_rst_n, c_start, c_sub, c_cin, c_ready, c_done, c_cout, c_ovf;
  logic [0:0] c_a, c_b, c_q;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut_a (
    .CLK(CLK), .RST_N(a_rst_n), .START(a_start), .SUB(a_sub), .A(a_a), .B(a_b),
    .CIN(a_cin), .READY(a_ready), .DONE(a_done), .Q(a_q), .COUT(a_cout), .OVF(a_ovf)
  );
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut_b (
    .CLK(CLK), .RST_N(b_rst_n), .START(b_start), .SUB(b_sub), .A(b_a), .B(b_b),
    .CIN(b_cin), .READY(b_ready), .DONE(b_done), .Q(b_q), .COUT(b_cout), .OVF(b_ovf)
  );
  serial_adder #(.WIDTH(1), .DIGIT(1)) u_dut_c (
    .CLK(CLK), .RST_N(c_rst_n), .START(c_start), .SUB(c_sub), .A(c_a), .B(c_b),
    .CIN(c_cin), .READY(c_ready), .DONE(c_done), .Q(c_q), .COUT(c_cout), .OVF(c_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers, independent of the cell chain.
  function automatic exp_t model(input int w, input int a_in, input int b_in, input int cin, input logic sub);
    exp_t e;
    int mask, half, a, b, s, sa, sb, r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    a = a_in & mask;
    b = b_in & mask;
    if (sub) begin
      s = a - b - cin;
      e.cout = (a < b + cin);
    end else begin
      s = a + b + cin;
      e.cout = ((s >> w) & 1) != 0;
    end
    e.q = 8'(s & mask);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    r = sub ? (sa - sb - cin) : (sa + sb + cin);
    e.ovf = (r > half - 1) || (r < -half);
    return e;
  endfunction

  task automatic drive(input int which, input logic start, input logic sub,
                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    case (which)
      0: begin a_start = start; a_sub = sub; a_a = a; a_b = b; a_cin = cin; end
      1: begin b_start = start; b_sub = sub; b_a = a; b_b = b; b_cin = cin; end
      default: begin c_start = start; c_sub = sub; c_a = a[0]; c_b = b[0]; c_cin = cin; end
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return a_done;
      1: return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic get_ready(input int which);
    case (which)
      0: return a_ready;
      1: return b_ready;
      default: return c_ready;
    endcase
  endfunction

  // Issue one operation at a negedge, push its expectation, wait for DONE.
  // lat counts edges from the accepting edge (inclusive) up to DONE being seen.
  task automatic run(input int which, input logic sub, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic glitch, output int lat);
    exp_t e;
    e = model((which == 2) ? 1 : 8, int'(a), int'(b), int'(cin), sub);
    case (which)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
    drive(which, 1'b1, sub, a, b, cin);
    lat = 0;
    while (lat < 40) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        check($sformatf("busy_%0d", which), 32'(get_ready(which)), 32'd0);
        drive(which, 1'b0, ~sub, ~a, ~b, ~cin);
      end
      if (glitch && lat == 3) drive(which, 1'b1, ~sub, a ^ 8'h5A, b ^ 8'hC3, ~cin);
      if (glitch && lat == 4) drive(which, 1'b0, sub, 8'h00, 8'hFF, cin);
      if (get_done(which)) break;
    end
    if (!get_done(which)) check($sformatf("timeout_%0d", which), 32'd0, 32'd1);
  endtask

  // Scoreboard monitors: every DONE pops one expectation.
  always @(negedge CLK) begin : mon_a
    exp_t e;
    if (a_done) begin
      done_a++;
      if (qa.size() == 0) check("a_spurious_done", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_q", 32'(a_q), 32'(e.q));
        check("a_cout", 32'(a_cout), 32'(e.cout));
        check("a_ovf", 32'(a_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge CLK) begin : mon_b
    exp_t e;
    if (b_done) begin
      done_b++;
      if (qb.size() == 0) check("b_spurious_done", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_q", 32'(b_q), 32'(e.q));
        check("b_cout", 32'(b_cout), 32'(e.cout));
        check("b_ovf", 32'(b_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge CLK) begin : mon_c
    exp_t e;
    if (c_done) begin
      done_c++;
      if (qc.size() == 0) check("c_spurious_done", 32'd1, 32'd0);
      else begin
        e = qc.pop_front();
        check("c_q", 32'(c_q), 32'(e.q[0]));
        check("c_cout", 32'(c_cout), 32'(e.cout));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_before;
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_q", 32'(a_q), 32'd0);
    check("rst_cout", 32'(a_cout), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_ready_b", 32'(b_ready), 32'd1);
    check("rst_ready_c", 32'(c_ready), 32'd1);
    @(negedge CLK);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    @(negedge CLK);

    // Basic add with latency, then carry/borrow/overflow corners.
    run(0, 1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, lat);
    check("a_lat_first", 32'(lat), 32'd9);
    run(0, 1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, lat);
    run(0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, lat);
    run(0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, lat);
    // Issued while the previous op sits in FIN: back-to-back acceptance.
    run(0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, lat);
    check("a_lat_b2b", 32'(lat), 32'd9);
    // START with different operands mid-RUN must be ignored.
    run(0, 1'b0, 8'h33, 8'h44, 1'b1, 1'b1, lat);
    check("a_lat_glitch", 32'(lat), 32'd9);
    @(negedge CLK);
    check("a_idle_hold_q", 32'(a_q), 32'h78);

    // Abort an operation with reset mid-RUN; no expectation is pushed.
    drive(0, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0);
    @(negedge CLK);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge CLK);
    n_before = done_a;
    a_rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(a_ready), 32'd1);
    check("abort_q", 32'(a_q), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_cout", 32'(a_cout), 32'd0);
    repeat (2) @(negedge CLK);
    a_rst_n = 1'b1;
    repeat (15) @(negedge CLK);
    check("abort_no_done", 32'(done_a), 32'(n_before));

    // DIGIT=4: latency plus random add/sub against the model.
    run(1, 1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, lat);
    check("b_lat_first", 32'(lat), 32'd3);
    for (int i = 0; i < 1000; i++) begin
      run(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, lat);
      check("b_lat", 32'(lat), 32'd3);
    end

    // WIDTH=1: full-adder truth table, one run per row.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run(2, 1'b0, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0, lat);
      check("c_lat", 32'(lat), 32'd2);
    end

    repeat (3) @(negedge CLK);
    check("a_pending", 32'(qa.size()), 32'd0);
    check("b_pending", 32'(qb.size()), 32'd0);
    check("c_pending", 32'(qc.size()), 32'd0);
    check("a_done_count", 32'(done_a), 32'd6);
    check("c_done_count", 32'(done_c), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
